result_fifo: RTL and testbench
==============================

Name: result_fifo

Overview:
- Output buffer stage directly downstream of the adder/subtractor/mux datapath.
- Captures each selected 8-bit result (mux output) qualified by a valid strobe into a small FIFO.
- Presents results to the consumer with a valid/ready handshake.
- Tracks occupancy, dropped results and a sticky overflow flag, so datapath bursts do not silently lose data.

Parameters:
- WIDTH, 8, data width of each result word; matches the mux output width.
- DEPTH, 4, number of FIFO entries; must be a power of 2, minimum 2.
- CW, $clog2(DEPTH+1), width of the occupancy count. Derived; 3 at default.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_l  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous flush: empties the FIFO and clears overflow and drop_cnt.
- in_data  input  WIDTH  result word from the mux output.
- in_valid  input  1  in_data is a new result this cycle.
- in_ready  output  1  FIFO can accept a write this cycle (equals !full).
- out_data  output  WIDTH  head-of-FIFO word (show-ahead).
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer takes out_data this cycle.
- count  output  CW  current number of stored entries.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky flag: a write was attempted while full.
- drop_cnt  output  8  number of dropped writes; saturates at 255.

Behaviour:
- Reset (reset_l low, asynchronous):
  - wr_ptr, rd_ptr and count = 0.
  - out_valid = 0, in_ready = 1, full = 0, overflow = 0, drop_cnt = 0.
  - out_data = 0; the memory contents are don't-care, but out_data is forced to 0 while empty.
- Reset deasserts synchronously to the design. The first write may occur on the first rising edge with reset_l high.
- Write fire = in_valid && in_ready.
  - Stores in_data at mem[wr_ptr].
  - wr_ptr increments modulo DEPTH.
- Read fire = out_valid && out_ready.
  - rd_ptr increments modulo DEPTH.
  - out_data is mem[rd_ptr], combinational from the registered memory: zero-latency show-ahead.
- Write-to-read latency: a word written at edge N is visible on out_data, with out_valid = 1, after edge N.
- Count update:
  - +1 on write only.
  - -1 on read only.
  - Unchanged when write and read fire on the same edge.
- in_ready depends only on registered full. When full, a same-cycle read does NOT enable a same-cycle write; in_ready rises the cycle after the read.
- in_valid while full:
  - The word is dropped.
  - overflow is set to 1 on that edge.
  - drop_cnt increments, saturating at 255.
  - FIFO contents and pointers are unchanged.
- Empty with in_valid and out_ready both high: the write fires; the read does not, because out_valid was 0. The word appears on the next cycle.
- Pointer wrap: both pointers wrap from DEPTH-1 to 0. Ordering is strictly first-in, first-out across the wrap.
- clear = 1 at an edge:
  - Pointers, count, overflow and drop_cnt all go to 0.
  - clear has priority over any write or read in the same cycle; those transfers are discarded.
- Reset asserted mid-operation immediately empties the FIFO (asynchronous). Outputs go to their reset values without waiting for a clock edge.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Test Plan:
1. Reset then single transfer:
   - Stimulus: assert reset_l = 0, release, write 0x2A, hold out_ready = 0.
   - Required: count = 1, out_valid = 1, out_data = 0x2A.
   - Then pulse out_ready: count = 0, out_valid = 0, out_data = 0.
2. Fill and overflow:
   - Stimulus: write 0x01, 0x02, 0x03, 0x04 with out_ready = 0, then in_valid with 0x05 for 3 cycles.
   - Required: full = 1, in_ready = 0, overflow = 1, drop_cnt = 3.
   - Draining yields 0x01..0x04 in order; 0x05 never appears.
3. Wrap-around streaming:
   - Stimulus: 10 consecutive writes 0x10..0x19 with out_ready = 1 throughout.
   - Required: outputs 0x10..0x19 in order, each appearing one cycle after its write; count never exceeds 1; no drops.
4. Simultaneous read/write at full:
   - Stimulus: FIFO full with 0xA0..0xA3, assert out_ready and in_valid (0xB0) in the same cycle.
   - Required: 0xA0 consumed, 0xB0 dropped, overflow = 1, count = 3; in_ready = 1 on the next cycle.
5. Clear priority:
   - Stimulus: count = 2, overflow = 1; assert clear together with in_valid (0x77) and out_ready.
   - Required next cycle: count = 0, out_valid = 0, overflow = 0, drop_cnt = 0; 0x77 is not stored.
6. Async reset mid-stream:
   - Stimulus: count = 3, pull reset_l low between clock edges.
   - Required: count = 0, out_valid = 0, in_ready = 1 immediately, with no clock edge needed.

Source files
------------

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - show-ahead result FIFO with overflow and drop accounting
module result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             clear,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             overflow,
    output logic [7:0]       drop_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_fire;
    logic             rd_fire;
    logic             drop;

    // Handshake qualifiers derive only from registered count, so there is
    // no combinational path from in_valid or out_ready to the flow-control outputs.
    always_comb begin
        full      = (count == CW'(DEPTH));
        out_valid = (count != '0);
        in_ready  = !full;
        wr_fire   = in_valid && in_ready;
        rd_fire   = out_valid && out_ready;
        drop      = in_valid && full;
        out_data  = out_valid ? mem[rd_ptr] : '0;
    end

    // Storage array; contents need no reset because out_data is masked while empty.
    always_ff @(posedge clk) begin
        if (wr_fire && !clear) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers, occupancy and drop accounting; clear overrides any same-cycle transfer.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_fire && !rd_fire) begin
                count <= count + CW'(1);
            end else if (rd_fire && !wr_fire) begin
                count <= count - CW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_result_fifo.sv
// tb/tb_result_fifo.sv - directed vector bench for result_fifo
module tb_result_fifo;

    logic       clk;
    logic       reset_l;
    logic       clear;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] count;
    logic       full;
    logic       overflow;
    logic [7:0] drop_cnt;

    int errors = 0;
    int checks = 0;

    result_fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .clk       (clk),
        .reset_l   (reset_l),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       clr;
        logic       vld;
        logic [7:0] din;
        logic       rdy;
        int         e_cnt;
        logic       e_ov;
        logic [7:0] e_od;
        logic       e_full;
        logic       e_ovf;
        int         e_drop;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic addv(input logic clr, input logic vld, input logic [7:0] din,
                        input logic rdy, input int e_cnt, input logic e_ov,
                        input logic [7:0] e_od, input logic e_full,
                        input logic e_ovf, input int e_drop);
        vec_t v;
        v.clr = clr; v.vld = vld; v.din = din; v.rdy = rdy;
        v.e_cnt = e_cnt; v.e_ov = e_ov; v.e_od = e_od;
        v.e_full = e_full; v.e_ovf = e_ovf; v.e_drop = e_drop;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic clr, input logic vld, input logic [7:0] din, input logic rdy);
        clear     = clr;
        in_valid  = vld;
        in_data   = din;
        out_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_l = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        tick();

        chk("reset count", int'(count), 0);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset in_ready", int'(in_ready), 1);
        chk("reset full", int'(full), 0);
        chk("reset overflow", int'(overflow), 0);
        chk("reset drop_cnt", int'(drop_cnt), 0);
        chk("reset out_data", int'(out_data), 0);
        reset_l = 1'b1;

        //   clr  vld  din    rdy  cnt ov  od     full ovf drop
        addv(0,   1,   8'h2A, 0,   1,  1,  8'h2A, 0,   0,  0);
        addv(0,   0,   8'h00, 1,   0,  0,  8'h00, 0,   0,  0);
        addv(0,   1,   8'h01, 0,   1,  1,  8'h01, 0,   0,  0);
        addv(0,   1,   8'h02, 0,   2,  1,  8'h01, 0,   0,  0);
        addv(0,   1,   8'h03, 0,   3,  1,  8'h01, 0,   0,  0);
        addv(0,   1,   8'h04, 0,   4,  1,  8'h01, 1,   0,  0);
        addv(0,   1,   8'h05, 0,   4,  1,  8'h01, 1,   1,  1);
        addv(0,   1,   8'h05, 0,   4,  1,  8'h01, 1,   1,  2);
        addv(0,   1,   8'h05, 0,   4,  1,  8'h01, 1,   1,  3);
        addv(0,   0,   8'h00, 1,   3,  1,  8'h02, 0,   1,  3);
        addv(0,   0,   8'h00, 1,   2,  1,  8'h03, 0,   1,  3);
        addv(0,   0,   8'h00, 1,   1,  1,  8'h04, 0,   1,  3);
        addv(0,   0,   8'h00, 1,   0,  0,  8'h00, 0,   1,  3);
        addv(1,   0,   8'h00, 0,   0,  0,  8'h00, 0,   0,  0);
        addv(0,   1,   8'hA0, 0,   1,  1,  8'hA0, 0,   0,  0);
        addv(0,   1,   8'hA1, 0,   2,  1,  8'hA0, 0,   0,  0);
        addv(0,   1,   8'hA2, 0,   3,  1,  8'hA0, 0,   0,  0);
        addv(0,   1,   8'hA3, 0,   4,  1,  8'hA0, 1,   0,  0);
        addv(0,   1,   8'hB0, 1,   3,  1,  8'hA1, 0,   1,  1);
        addv(0,   0,   8'h00, 0,   3,  1,  8'hA1, 0,   1,  1);
        addv(0,   0,   8'h00, 1,   2,  1,  8'hA2, 0,   1,  1);
        addv(1,   1,   8'h77, 1,   0,  0,  8'h00, 0,   0,  0);
        addv(0,   0,   8'h00, 0,   0,  0,  8'h00, 0,   0,  0);

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].vld, vecs[i].din, vecs[i].rdy);
            tick();
            chk($sformatf("vec%0d count", i), int'(count), vecs[i].e_cnt);
            chk($sformatf("vec%0d out_valid", i), int'(out_valid), int'(vecs[i].e_ov));
            chk($sformatf("vec%0d out_data", i), int'(out_data), int'(vecs[i].e_od));
            chk($sformatf("vec%0d full", i), int'(full), int'(vecs[i].e_full));
            chk($sformatf("vec%0d in_ready", i), int'(in_ready), int'(!vecs[i].e_full));
            chk($sformatf("vec%0d overflow", i), int'(overflow), int'(vecs[i].e_ovf));
            chk($sformatf("vec%0d drop_cnt", i), int'(drop_cnt), vecs[i].e_drop);
        end

        // Streaming across pointer wrap: each word shows up right after its write edge.
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 8'(8'h10 + i), 1'b1);
            tick();
            chk($sformatf("stream%0d count", i), int'(count), 1);
            chk($sformatf("stream%0d out_valid", i), int'(out_valid), 1);
            chk($sformatf("stream%0d out_data", i), int'(out_data), 16 + i);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        chk("stream end count", int'(count), 0);
        chk("stream end out_valid", int'(out_valid), 0);
        chk("stream drop_cnt", int'(drop_cnt), 0);
        chk("stream overflow", int'(overflow), 0);

        // Drop counter saturates at 255 while contents stay intact.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
            tick();
        end
        for (int i = 0; i < 260; i++) begin
            drive(1'b0, 1'b1, 8'hEE, 1'b0);
            tick();
        end
        chk("sat drop_cnt", int'(drop_cnt), 255);
        chk("sat overflow", int'(overflow), 1);
        chk("sat count", int'(count), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("sat drain%0d", i), int'(out_data), 8'hC0 + i);
            drive(1'b0, 1'b0, 8'h00, 1'b1);
            tick();
        end
        chk("sat drained valid", int'(out_valid), 0);

        // Asynchronous reset mid-stream with three entries held.
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 8'(8'h50 + i), 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("pre-reset count", int'(count), 3);
        #2;
        reset_l = 1'b0;
        #1;
        chk("async count", int'(count), 0);
        chk("async out_valid", int'(out_valid), 0);
        chk("async in_ready", int'(in_ready), 1);
        chk("async out_data", int'(out_data), 0);
        tick();
        reset_l = 1'b1;
        drive(1'b0, 1'b1, 8'h99, 1'b0);
        tick();
        chk("post-reset count", int'(count), 1);
        chk("post-reset out_data", int'(out_data), 8'h99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
